// File: rtl/systolic_pkg.sv
// Shared constants, FSM state encoding and saturating add for the systolic stream matmul engine.
// The saturating path is only exercised when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned SAT_W      = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] sum;
  } sat_res_t;

  // Add on a wide datapath, then clamp into a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             w);
    sat_res_t                res;
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi      = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo      = ~hi;
    s       = a + b;
    res.sat = 1'b0;
    res.sum = s;
    if (s > hi) begin
      res.sum = hi;
      res.sat = 1'b1;
    end else if (s < lo) begin
      res.sum = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_stream_mm_if.sv
// Operand (A column + B row) input stream and C row output stream of the systolic engine.
interface systolic_stream_mm_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] a_col;
  logic [COLS*DATA_W-1:0] b_row;
  logic                   c_valid;
  logic                   c_ready;
  logic [COLS*ACC_W-1:0]  c_row_data;
  logic [RW-1:0]          c_row_idx;
  logic                   c_last;

  // Operand source / result sink side.
  modport master (
    output in_valid, a_col, b_row, c_ready,
    input  in_ready, c_valid, c_row_data, c_row_idx, c_last
  );

  // Engine side.
  modport slave (
    input  in_valid, a_col, b_row, c_ready,
    output in_ready, c_valid, c_row_data, c_row_idx, c_last
  );
endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards a right and b down, accumulates a*b.
// SYSTOLIC_SAT_EN selects a saturating accumulator; otherwise it wraps.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_nx;
  logic                       sat_nx;

  assign prod = a_in * b_in;

`ifdef SYSTOLIC_SAT_EN
  sat_res_t sum;
  assign sum    = sat_add(SAT_W'(acc), SAT_W'(prod), ACC_W);
  assign acc_nx = ACC_W'(sum.sum);
  assign sat_nx = sum.sat;
`else
  assign acc_nx = acc + ACC_W'(prod);
  assign sat_nx = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (en) begin
        acc <= acc_nx;
        sat <= sat_nx;
      end else begin
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/systolic_stream_mm.sv
// Output-stationary ROWSxCOLS systolic matmul with streamed k-steps, runtime K and row-wise drain.
// Define SYSTOLIC_SAT_EN to make the accumulators saturate and report it on sat_flag.
module systolic_stream_mm
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned K_MAX  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         acc_mode,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag,
  systolic_stream_mm_if.slave          bus
);

  localparam int unsigned KW        = $clog2(K_MAX + 1);
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned FLUSH_CYC = ROWS + COLS - 1;
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_nx;
  logic          launch;
  logic          accept;
  logic          c_fire;
  logic          row_last;
  logic          pe_en;
  logic          pe_clr;

  logic signed [DATA_W-1:0] a_w   [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_w   [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc_g [ROWS][COLS];
  logic [ROWS*COLS-1:0]     sat_vec;
  logic [COLS*ACC_W-1:0]    row_sel;

  assign launch   = (state == ST_IDLE) && start;
  assign accept   = bus.in_valid && bus.in_ready;
  assign c_fire   = bus.c_valid && bus.c_ready;
  assign row_last = (bus.c_row_idx == RW'(ROWS - 1));
  assign pe_en    = (state == ST_LOAD) || (state == ST_FLUSH);
  assign pe_clr   = launch && !acc_mode;

  // Next state and next drain row.
  always_comb begin
    state_nx = state;
    row_nx   = '0;
    case (state)
      ST_IDLE:  if (start) state_nx = (k_len == '0) ? ST_FLUSH : ST_LOAD;
      ST_LOAD:  if (accept && (k_cnt == KW'(k_len_q - KW'(1)))) state_nx = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == FW'(FLUSH_CYC - 1)) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        row_nx = c_fire ? RW'(bus.c_row_idx + 1'b1) : bus.c_row_idx;
        if (c_fire && row_last) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= (state == ST_FLUSH) ? FW'(flush_cnt + 1'b1) : '0;
      if (launch) begin
        k_len_q <= k_len;
        k_cnt   <= '0;
      end else if (accept) begin
        k_cnt   <= KW'(k_cnt + 1'b1);
      end
    end
  end

  // Row multiplexer feeding the registered result port.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_nx == RW'(r)) begin
        for (int c = 0; c < COLS; c++) row_sel[c*ACC_W +: ACC_W] = acc_g[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      sat_flag       <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.c_valid    <= 1'b0;
      bus.c_row_idx  <= '0;
      bus.c_row_data <= '0;
      bus.c_last     <= 1'b0;
    end else begin
      busy           <= (state_nx != ST_IDLE);
      done           <= (state_nx == ST_DONE);
      bus.in_ready   <= (state_nx == ST_LOAD);
      bus.c_valid    <= (state_nx == ST_DRAIN);
      bus.c_row_idx  <= (state_nx == ST_DRAIN) ? row_nx : '0;
      bus.c_row_data <= (state_nx == ST_DRAIN) ? row_sel : '0;
      bus.c_last     <= (state_nx == ST_DRAIN) && (row_nx == RW'(ROWS - 1));
      if (launch) sat_flag <= 1'b0;
      else if (|sat_vec) sat_flag <= 1'b1;
    end
  end

  // A row r is delayed r cycles; bubbles inject zeros so stalls never add stale products.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
    logic signed [DATA_W-1:0] inj;
    assign inj = accept ? $signed(bus.a_col[gr*DATA_W +: DATA_W]) : '0;
    if (gr == 0) begin : g_d0
      assign a_w[gr][0] = inj;
    end else begin : g_dn
      logic signed [DATA_W-1:0] sr [gr];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < gr; i++) sr[i] <= '0;
        end else begin
          sr[0] <= inj;
          for (int i = 1; i < gr; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_w[gr][0] = sr[gr-1];
    end
  end

  // B column c is delayed c cycles.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
    logic signed [DATA_W-1:0] inj;
    assign inj = accept ? $signed(bus.b_row[gc*DATA_W +: DATA_W]) : '0;
    if (gc == 0) begin : g_d0
      assign b_w[0][gc] = inj;
    end else begin : g_dn
      logic signed [DATA_W-1:0] sr [gc];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < gc; i++) sr[i] <= '0;
        end else begin
          sr[0] <= inj;
          for (int i = 1; i < gc; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_w[0][gc] = sr[gc-1];
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pe_clr),
        .en    (pe_en),
        .a_in  (a_w[gr][gc]),
        .b_in  (b_w[gr][gc]),
        .a_out (a_w[gr][gc+1]),
        .b_out (b_w[gr+1][gc]),
        .acc   (acc_g[gr][gc]),
        .sat   (sat_vec[gr*COLS+gc])
      );
    end
  end

endmodule

// File: tb/tb_systolic_stream_mm.sv
// Bench for systolic_stream_mm: randomized jobs against a plain matrix-product model,
// plus a 16-bit accumulator instance for the wrap/saturate (SYSTOLIC_SAT_EN) corner.
module tb_systolic_stream_mm;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned KM = 256;
  localparam int unsigned KW = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, acc_mode, busy, done, sat_flag;
  logic [KW-1:0] k_len;
  logic          start16, acc_mode16, busy16, done16, sat16;
  logic [KW-1:0] k_len16;

  systolic_stream_mm_if #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C)) bus ();
  systolic_stream_mm_if #(.DATA_W(DW), .ACC_W(16), .ROWS(R), .COLS(C)) bus16 ();

  systolic_stream_mm #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
    .busy(busy), .done(done), .sat_flag(sat_flag), .bus(bus.slave)
  );

  systolic_stream_mm #(.DATA_W(DW), .ACC_W(16), .ROWS(R), .COLS(C), .K_MAX(KM)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .k_len(k_len16), .acc_mode(acc_mode16),
    .busy(busy16), .done(done16), .sat_flag(sat16), .bus(bus16.slave)
  );

  int  n_chk = 0;
  int  n_err = 0;
  int  exp_c [R][C];
  int  cap   [R][C];
  byte am    [R][KM];
  byte bm    [KM][C];
  bit  loading   = 1'b0;
  bit  done_seen = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle check of the main instance against the model.
  task automatic compare_loop();
    int exp_row = 0;
    bit last_q  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_row = 0;
        last_q  = 1'b0;
      end else begin
        chk("in_ready", bus.in_ready, loading);
        chk("done_pulse", done, last_q);
        if (done) done_seen = 1'b1;
        last_q = 1'b0;
        if (bus.c_valid) begin
          chk("row_idx", bus.c_row_idx, exp_row);
          chk("c_last", bus.c_last, exp_row == R - 1);
          for (int c = 0; c < C; c++)
            chk("c_data", $signed(bus.c_row_data[c*AW +: AW]), exp_c[exp_row][c]);
          if (bus.c_ready) begin
            for (int c = 0; c < C; c++) cap[exp_row][c] = $signed(bus.c_row_data[c*AW +: AW]);
            last_q  = (exp_row == R - 1);
            exp_row = last_q ? 0 : exp_row + 1;
          end
        end
      end
    end
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random. cmode: 0 always ready, 1 stall row 1, 2 random.
  task automatic run_job(input int k, input bit accm, input int vmode, input int cmode);
    int i, cyc, stall;
    bit v, fire;
    if (!accm) for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = 0;
    for (int kk = 0; kk < k; kk++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          exp_c[r][c] += int'(am[r][kk]) * int'(bm[kk][c]);
    @(posedge clk); #2;
    start = 1'b1; k_len = KW'(k); acc_mode = accm; done_seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    loading = (k > 0);
    i = 0; cyc = 0;
    while (i < k && cyc < 4000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom % 2) == 0;
      endcase
      bus.in_valid = v;
      for (int r = 0; r < R; r++) bus.a_col[r*DW +: DW] = am[r][i];
      for (int c = 0; c < C; c++) bus.b_row[c*DW +: DW] = bm[i][c];
      fire = v && bus.in_ready;
      @(posedge clk); #2;
      cyc++;
      if (fire) begin
        i++;
        if (i == k) loading = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    if (i < k) chk("feed_timeout", i, k);
    cyc = 0; stall = 0;
    while (!done_seen && cyc < 400) begin
      case (cmode)
        0: bus.c_ready = 1'b1;
        1: begin
          if (bus.c_valid && bus.c_row_idx == 2'd1 && stall < 5) begin
            bus.c_ready = 1'b0;
            stall++;
          end else bus.c_ready = 1'b1;
        end
        default: bus.c_ready = ($urandom % 3) != 0;
      endcase
      @(posedge clk); #2;
      cyc++;
    end
    chk("done_seen", done_seen, 1);
    chk("sat_flag", sat_flag, 0);
    if (cmode == 1) chk("stall_cycles", stall, 5);
  endtask

  task automatic chk_cap_all(input string nm, input int v);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) chk(nm, cap[r][c], v);
  endtask

  task automatic fill_t1();
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < R; r++) am[r][kk] = (r == kk) ? 8'sd1 : 8'sd0;
      for (int c = 0; c < C; c++) bm[kk][c] = byte'(4 * kk + c + 1);
    end
  endtask

  task automatic fill_const(input int k, input byte a, input byte b);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < R; r++) am[r][kk] = a;
      for (int c = 0; c < C; c++) bm[kk][c] = b;
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < R; r++) am[r][kk] = byte'($urandom);
      for (int c = 0; c < C; c++) bm[kk][c] = byte'($urandom);
    end
  endtask

  initial begin
    int k, fires, rows, cyc;
    bit accm;
    longint exp16;
    longint exp_sat16;
`ifdef SYSTOLIC_SAT_EN
    exp16 = 32767;     exp_sat16 = 1;
`else
    exp16 = -32768;    exp_sat16 = 0;
`endif
    start = 0; k_len = '0; acc_mode = 0;
    bus.in_valid = 0; bus.a_col = '0; bus.b_row = '0; bus.c_ready = 0;
    start16 = 0; k_len16 = '0; acc_mode16 = 0;
    bus16.in_valid = 0; bus16.a_col = '0; bus16.b_row = '0; bus16.c_ready = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = 0;
    fork
      compare_loop();
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_c_valid", bus.c_valid, 0);
    chk("rst_c_last", bus.c_last, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_c_data", |bus.c_row_data, 0);
    rst_n = 1'b1;

    // 1: identity A, B[k][c]=4k+c+1.
    fill_t1();
    run_job(4, 0, 0, 0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) chk("t1_lit", cap[r][c], 4 * r + c + 1);

    // 2/3: all-ones A, B=2, k=8, gapped input; then accumulate and clear again.
    fill_const(8, 8'sd1, 8'sd2);
    run_job(8, 0, 1, 0);
    chk_cap_all("t2_lit", 16);
    run_job(8, 1, 1, 0);
    chk_cap_all("t3_acc_lit", 32);
    run_job(8, 0, 1, 0);
    chk_cap_all("t3_clr_lit", 16);

    // 4: result back-pressure on row 1.
    fill_t1();
    run_job(4, 0, 0, 1);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) chk("t4_lit", cap[r][c], 4 * r + c + 1);

    // Randomized jobs, random valid/ready, random accumulate.
    for (int j = 0; j < 8; j++) begin
      k = $urandom_range(1, 20);
      accm = (j > 0) && (($urandom % 2) == 1);
      fill_rand(k);
      run_job(k, accm, 2, 2);
    end
    fill_rand(KM);
    run_job(KM, 0, 0, 2);
    fill_rand(1);
    run_job(1, 1, 2, 2);

    // 6: reset mid-LOAD, then a fresh job, then k_len=0.
    fill_const(8, 8'sd3, 8'sd5);
    @(posedge clk); #2;
    start = 1'b1; k_len = KW'(8); acc_mode = 1'b0;
    @(posedge clk); #2;
    start = 1'b0; loading = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b0; loading = 1'b0; bus.in_valid = 1'b0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    fill_t1();
    run_job(4, 0, 2, 0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) chk("t6_lit", cap[r][c], 4 * r + c + 1);
    run_job(0, 0, 0, 0);
    chk_cap_all("t6_k0_lit", 0);

    // 5: 16-bit accumulators, A=B=-128, k=2.
    @(posedge clk); #2;
    start16 = 1'b1; k_len16 = KW'(2); acc_mode16 = 1'b0;
    @(posedge clk); #2;
    start16 = 1'b0;
    bus16.a_col = {R{8'h80}};
    bus16.b_row = {C{8'h80}};
    bus16.in_valid = 1'b1;
    bus16.c_ready = 1'b1;
    fires = 0; cyc = 0;
    while (fires < 2 && cyc < 50) begin
      if (bus16.in_ready) fires++;
      @(posedge clk); #2;
      cyc++;
    end
    bus16.in_valid = 1'b0;
    chk("t5_beats", fires, 2);
    rows = 0; cyc = 0;
    while (!done16 && cyc < 200) begin
      @(negedge clk);
      if (bus16.c_valid) begin
        chk("t5_idx", bus16.c_row_idx, rows);
        chk("t5_last", bus16.c_last, rows == R - 1);
        for (int c = 0; c < C; c++) chk("t5_c", $signed(bus16.c_row_data[c*16 +: 16]), exp16);
        rows++;
      end
      cyc++;
    end
    chk("t5_rows", rows, 4);
    @(negedge clk);
    chk("t5_sat_flag", sat16, exp_sat16);
    chk("t5_busy_after", busy16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
